// File: rtl/mips_test_sequencer.sv
// Run controller for pipe_MIPS32 bring-up: loads a program image, runs the CPU
// under a watchdog, then compares a window of registers against expected values.
module mips_test_sequencer #(
  parameter int DATA_W     = 32,
  parameter int IMEM_AW    = 10,
  parameter int PROG_DEPTH = 16,
  parameter int RF_AW      = 5,
  parameter int NUM_CHECK  = 6,
  parameter int CHECK_BASE = 0,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_W      = 16
) (
  input  logic                           clk1,
  input  logic                           rst,
  input  logic                           start,
  input  logic [IMEM_AW:0]               prog_len,
  output logic [IMEM_AW-1:0]             prog_addr,
  input  logic [DATA_W-1:0]              prog_data,
  output logic                           imem_we,
  output logic [IMEM_AW-1:0]             imem_addr,
  output logic [DATA_W-1:0]              imem_wdata,
  output logic                           cpu_run,
  input  logic                           cpu_halted,
  output logic [RF_AW-1:0]               rf_raddr,
  input  logic [DATA_W-1:0]              rf_rdata,
  input  logic [DATA_W-1:0]              exp_data,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic                           timeout,
  output logic [$clog2(NUM_CHECK+1)-1:0] fail_idx,
  output logic [CNT_W-1:0]               cycle_count
);

  localparam int FI_W = $clog2(NUM_CHECK+1);
  localparam int PL_W = IMEM_AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_CHECK, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [PL_W-1:0]   len_q, len_d;
  logic [PL_W-1:0]   ld_cnt_q, ld_cnt_d;
  logic              we_q, we_d;
  logic [IMEM_AW-1:0] waddr_q, waddr_d;
  logic [FI_W-1:0]   chk_q, chk_d;
  logic [FI_W-1:0]   fail_idx_q, fail_idx_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PL_W-1:0]   len_clamped;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    ld_cnt_d   = ld_cnt_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    chk_d      = chk_q;
    fail_idx_d = fail_idx_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    cnt_d      = cnt_q;
    len_clamped = (prog_len > PL_W'(PROG_DEPTH)) ? PL_W'(PROG_DEPTH) : prog_len;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_LOAD;
          len_d      = len_clamped;
          ld_cnt_d   = '0;
          chk_d      = '0;
          pass_d     = 1'b0;
          timeout_d  = 1'b0;
          cnt_d      = '0;
          fail_idx_d = FI_W'(NUM_CHECK);
        end
      end
      S_LOAD: begin
        // ROM data arrives a cycle after its address, so the write is issued
        // one cycle behind; the extra LOAD cycle drains the final write.
        if (ld_cnt_q < len_q) begin
          we_d     = 1'b1;
          waddr_d  = ld_cnt_q[IMEM_AW-1:0];
          ld_cnt_d = ld_cnt_q + 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cpu_halted) begin
          state_d = S_CHECK;
          chk_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (rf_rdata != exp_data) begin
          state_d    = S_DONE;
          fail_idx_d = chk_q;
          pass_d     = 1'b0;
        end else if (chk_q == FI_W'(NUM_CHECK - 1)) begin
          state_d    = S_DONE;
          fail_idx_d = FI_W'(NUM_CHECK);
          pass_d     = 1'b1;
        end else begin
          chk_d = chk_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      ld_cnt_q   <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      chk_q      <= '0;
      fail_idx_q <= FI_W'(NUM_CHECK);
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      ld_cnt_q   <= ld_cnt_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      chk_q      <= chk_d;
      fail_idx_q <= fail_idx_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      cnt_q      <= cnt_d;
    end
  end

  // Strobes are masked by rst so the CPU side is quiet from the reset cycle on.
  always_comb begin
    prog_addr   = (state_q == S_LOAD && ld_cnt_q < len_q) ? ld_cnt_q[IMEM_AW-1:0] : '0;
    imem_we     = we_q && !rst;
    imem_addr   = waddr_q;
    imem_wdata  = imem_we ? prog_data : '0;
    cpu_run     = (state_q == S_RUN) && !rst;
    rf_raddr    = (state_q == S_CHECK) ? RF_AW'(CHECK_BASE) + RF_AW'(chk_q) : '0;
    busy        = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_CHECK);
    done        = (state_q == S_DONE);
    pass        = pass_q;
    timeout     = timeout_q;
    fail_idx    = fail_idx_q;
    cycle_count = cnt_q;
  end

endmodule
